// File: rtl/mem_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mem_arbiter : round-robin two-requester arbiter for a shared tri-state SRAM
// Revision    : 1.0
// ---------------------------------------------------------------------------
module mem_arbiter #(
  parameter int AW = 5,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          a_req,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  input  logic          b_req,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic          a_ack,
  output logic          b_ack,
  output logic [DW-1:0] a_rdata,
  output logic [DW-1:0] b_rdata,
  output logic          busy,
  output logic [AW-1:0] mem_addr,
  output logic          mem_read,
  output logic          mem_write,
  inout  wire  [DW-1:0] mem_data
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] SETUP = 3'd1;
  localparam logic [2:0] WSTRB = 3'd2;
  localparam logic [2:0] RSTRB = 3'd3;
  localparam logic [2:0] ACK   = 3'd4;

  logic [2:0]    state, state_nxt;
  logic          ptr_b, grant_b, we_q, drive;
  logic [DW-1:0] wdata_q;

  logic          any_req, pick_b, grant_now, sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;
  logic          busy_nxt, rd_nxt, wr_nxt, a_ack_nxt, b_ack_nxt, drive_nxt;

  assign any_req   = a_req | b_req;
  assign pick_b    = (a_req & b_req) ? ptr_b : b_req;
  assign grant_now = (state == IDLE) & any_req;
  assign sel_we    = pick_b ? b_we    : a_we;
  assign sel_addr  = pick_b ? b_addr  : a_addr;
  assign sel_wdata = pick_b ? b_wdata : a_wdata;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = SETUP;
      SETUP:   state_nxt = we_q ? WSTRB : RSTRB;
      WSTRB:   state_nxt = ACK;
      RSTRB:   state_nxt = ACK;
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they become valid registers
  // in the same cycle the FSM enters the corresponding state.
  always_comb begin
    busy_nxt  = (state_nxt != IDLE);
    rd_nxt    = (state_nxt == RSTRB);
    wr_nxt    = (state_nxt == WSTRB);
    a_ack_nxt = (state_nxt == ACK) & ~grant_b;
    b_ack_nxt = (state_nxt == ACK) &  grant_b;
    drive_nxt = ((state == IDLE) ? sel_we : we_q) &
                ((state_nxt == SETUP) | (state_nxt == WSTRB) | (state_nxt == ACK));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy      <= 1'b0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      a_ack     <= 1'b0;
      b_ack     <= 1'b0;
      drive     <= 1'b0;
      ptr_b     <= 1'b0;
      grant_b   <= 1'b0;
      we_q      <= 1'b0;
      mem_addr  <= '0;
      wdata_q   <= '0;
      a_rdata   <= '0;
      b_rdata   <= '0;
    end else begin
      busy      <= busy_nxt;
      mem_read  <= rd_nxt;
      mem_write <= wr_nxt;
      a_ack     <= a_ack_nxt;
      b_ack     <= b_ack_nxt;
      drive     <= drive_nxt;
      if (grant_now) begin
        grant_b  <= pick_b;
        ptr_b    <= ~pick_b;
        we_q     <= sel_we;
        mem_addr <= sel_addr;
        wdata_q  <= sel_wdata;
      end
      if (state == RSTRB) begin
        if (grant_b) b_rdata <= mem_data;
        else         a_rdata <= mem_data;
      end
    end
  end

  assign mem_data = drive ? wdata_q : {DW{1'bz}};

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// Directed bench for mem_arbiter: behavioural 32x8 memory on the shared bus,
// bus-release probe drives 8'h5A when nobody else should be driving.
module tb_mem_arbiter;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       a_req = 0, a_we = 0, b_req = 0, b_we = 0;
  logic [4:0] a_addr = 0, b_addr = 0;
  logic [7:0] a_wdata = 0, b_wdata = 0;
  logic       a_ack, b_ack, busy, mem_read, mem_write;
  logic [7:0] a_rdata, b_rdata;
  logic [4:0] mem_addr;
  wire  [7:0] mem_data;

  logic [7:0] mem [32];
  logic       probe = 1'b0;
  logic [7:0] a_exp = 8'h00, b_exp = 8'h00;
  int         n_cmp = 0, n_bad = 0;

  mem_arbiter #(.AW(5), .DW(8)) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .a_ack(a_ack), .b_ack(b_ack), .a_rdata(a_rdata), .b_rdata(b_rdata),
    .busy(busy), .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write),
    .mem_data(mem_data)
  );

  always #5 clk = ~clk;

  assign mem_data = mem_read ? mem[mem_addr] : (probe ? 8'h5A : 8'hzz);

  always @(posedge clk) if (mem_write) mem[mem_addr] <= mem_data;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_bus_free(input string tag);
    probe = 1'b1;
    #1;
    check(tag, {24'h0, mem_data}, 32'h5A);
    probe = 1'b0;
  endtask

  // One isolated transaction; checks every phase at fixed latency.
  task automatic txn(input bit use_b, input bit we, input logic [4:0] addr,
                     input logic [7:0] wd, input logic [7:0] rd_exp);
    @(negedge clk);
    if (use_b) begin b_req = 1; b_we = we; b_addr = addr; b_wdata = wd; end
    else       begin a_req = 1; a_we = we; a_addr = addr; a_wdata = wd; end
    @(posedge clk); #1;
    check("setup_busy", busy, 1);
    check("setup_strb", {mem_read, mem_write}, 0);
    check("setup_addr", mem_addr, addr);
    if (use_b) begin b_we = ~we; b_addr = ~addr; b_wdata = ~wd; end
    else       begin a_we = ~we; a_addr = ~addr; a_wdata = ~wd; end
    if (we) check("setup_data", mem_data, wd);
    else    chk_bus_free("rd_setup_bus");
    @(posedge clk); #1;
    check("strb_wr", mem_write, we);
    check("strb_rd", mem_read, !we);
    check("strb_addr", mem_addr, addr);
    if (we) check("strb_data", mem_data, wd);
    @(posedge clk); #1;
    check("ack_own", use_b ? b_ack : a_ack, 1);
    check("ack_other", use_b ? a_ack : b_ack, 0);
    check("ack_strb", {mem_read, mem_write}, 0);
    check("ack_addr", mem_addr, addr);
    if (we) check("ack_hold", mem_data, wd);
    else begin
      chk_bus_free("rd_ack_bus");
      if (use_b) b_exp = rd_exp; else a_exp = rd_exp;
    end
    check("a_rdata", a_rdata, a_exp);
    check("b_rdata", b_rdata, b_exp);
    if (use_b) b_req = 0; else a_req = 0;
    @(posedge clk); #1;
    check("idle_ack", {a_ack, b_ack}, 0);
    check("idle_busy", busy, 0);
    chk_bus_free("idle_bus");
  endtask

  // Exclusivity monitor across the whole run.
  always @(negedge clk) begin
    if (!rst) begin
      check("strobe_overlap", {31'h0, mem_read & mem_write}, 0);
      check("ack_overlap", {31'h0, a_ack & b_ack}, 0);
    end
  end

  initial begin
    logic exp_order [4];
    int   idx, last, na, nb;
    bit   got;
    exp_order = '{1'b0, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 32; i++) mem[i] = 8'h00;

    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_acks", {a_ack, b_ack}, 0);
    check("rst_strb", {mem_read, mem_write}, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_rdata", {a_rdata, b_rdata}, 0);
    chk_bus_free("rst_bus");
    @(negedge clk); rst = 0;

    txn(0, 1, 5'h0A, 8'hAA, 8'h00);
    txn(0, 0, 5'h0A, 8'h00, 8'hAA);

    for (int i = 0; i < 32; i++) txn(0, 1, i[4:0], i[0] ? 8'h55 : 8'hAA, 8'h00);
    txn(1, 0, 5'h05, 8'h00, 8'h55);
    txn(1, 0, 5'h06, 8'h00, 8'hAA);
    txn(1, 0, 5'h07, 8'h00, 8'h55);
    txn(1, 0, 5'h08, 8'h00, 8'hAA);
    txn(1, 0, 5'h09, 8'h00, 8'h55);

    // Both request together; last grant was B so pointer favours A.
    @(negedge clk);
    a_req = 1; a_we = 1; a_addr = 5'h10; a_wdata = 8'h11;
    b_req = 1; b_we = 1; b_addr = 5'h11; b_wdata = 8'h22;
    idx = 0; last = 0; na = 0; nb = 0;
    for (int c = 0; c < 40 && idx < 4; c++) begin
      @(posedge clk); #1;
      if (a_ack || b_ack) begin
        check("arb_who", b_ack, exp_order[idx]);
        if (idx > 0) check("arb_gap", c - last, 4);
        last = c;
        idx++;
        if (a_ack) begin na++; if (na == 2) a_req = 0; end
        if (b_ack) begin nb++; if (nb == 2) b_req = 0; end
      end
    end
    check("arb_count", idx, 4);
    a_req = 0; b_req = 0;
    @(posedge clk); #1;
    check("arb_idle", busy, 0);

    // Reset during the write strobe aborts the transaction.
    txn(0, 1, 5'h03, 8'h00, 8'h00);
    @(negedge clk);
    a_req = 1; a_we = 1; a_addr = 5'h03; a_wdata = 8'hFF;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("abort_wstrb", mem_write, 1);
    @(negedge clk); rst = 1; a_req = 0;
    @(posedge clk); #1;
    check("abort_strb", {mem_read, mem_write}, 0);
    check("abort_ack", {a_ack, b_ack}, 0);
    check("abort_busy", busy, 0);
    check("abort_addr", mem_addr, 0);
    check("abort_rdata", {a_rdata, b_rdata}, 0);
    chk_bus_free("abort_bus");
    a_exp = 8'h00; b_exp = 8'h00;
    @(negedge clk); rst = 0;
    repeat (3) begin
      @(posedge clk); #1;
      check("abort_no_ack", {a_ack, b_ack}, 0);
    end

    // Pointer is back at A after reset.
    @(negedge clk);
    a_req = 1; a_we = 0; a_addr = 5'h0A;
    b_req = 1; b_we = 0; b_addr = 5'h0B;
    got = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (a_ack || b_ack) begin got = 1; break; end
    end
    check("rr_first_seen", got, 1);
    check("rr_first_is_a", a_ack, 1);
    check("rr_first_rdata", a_rdata, 8'hAA);
    check("rr_b_untouched", b_rdata, 8'h00);
    a_req = 0;
    got = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (a_ack || b_ack) begin got = 1; break; end
    end
    check("rr_second_seen", got, 1);
    check("rr_second_is_b", b_ack, 1);
    check("rr_second_rdata", b_rdata, 8'h55);
    check("rr_a_held", a_rdata, 8'hAA);
    b_req = 0;
    repeat (2) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
`default_nettype wire
